// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle radix-2 restoring divider (DIV/DIVU), one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_raw;
    logic             neg_q, neg_r, dvs_zero;
    logic [WIDTH:0]   shifted, trial;

    logic accept;
    assign accept = (state == IDLE) && start;

    // One extra bit so the borrow of the trial subtract is visible in trial[WIDTH]
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            dvd_raw  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dvs_zero <= 1'b0;
        end else if (accept) begin
            // Magnitudes are plain unsigned, so |MIN| = 2^(WIDTH-1) needs no extra bit
            cnt      <= CW'(WIDTH);
            rem      <= '0;
            quo      <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_mag  <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
            dvd_raw  <= dividend;
            neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r    <= is_signed && dividend[WIDTH-1];
            dvs_zero <= (divisor == '0);
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done        <= 1'b0;
            lo          <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                div_by_zero <= dvs_zero;
                if (dvs_zero) begin
                    lo <= '1;
                    hi <= dvd_raw;
                end else begin
                    lo <= neg_q ? -quo : quo;
                    hi <= neg_r ? -rem : rem;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8
module tb_seq_divider;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int unsigned issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, is_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] lo, hi;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  dvd8 = '0, dvs8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  lo8, hi8;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        m32, m8;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .lo(lo), .hi(hi), .div_by_zero(div_by_zero)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .lo(lo8), .hi(hi8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: widen to 64 bits so MIN/-1 cannot overflow, then truncate to w bits
    function automatic exp_t model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint mask, sa, sb, q, r;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        e.issue = 0;
        if (sb == 0) begin
            e.lo  = 32'(mask);
            e.hi  = 32'(sa & mask);
            e.dbz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.lo  = 32'(q & mask);
            e.hi  = 32'(r & mask);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h1 << (w - 1);
            4:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'h1 << w) - 1);
        return v;
    endfunction

    task automatic wait_idle(input bit w8);
        for (int i = 0; i < 200 && (w8 ? busy8 : busy); i++) @(negedge clk);
        if (w8 ? busy8 : busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout w8=%0d", w8);
        end
    endtask

    task automatic send(input bit w8, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic edbz);
        exp_t e;
        wait_idle(w8);
        e.lo = elo; e.hi = ehi; e.dbz = edbz; e.issue = cyc + 1;
        if (w8) begin
            start8 = 1'b1; sgn8 = sgn; dvd8 = a[7:0]; dvs8 = b[7:0];
            q8.push_back(e);
        end else begin
            start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
            q32.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic send_rand(input bit w8);
        exp_t        e;
        bit          sgn;
        logic [31:0] a, b;
        sgn = 1'($urandom_range(0, 1));
        a = pick(w8 ? 8 : 32);
        b = pick(w8 ? 8 : 32);
        e = model(w8 ? 8 : 32, sgn, a, b);
        send(w8, sgn, a, b, e.lo, e.hi, e.dbz);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done32");
            end else begin
                m32 = q32.pop_front();
                chk("lo32", lo, m32.lo);
                chk("hi32", hi, m32.hi);
                chk("dbz32", {31'b0, div_by_zero}, {31'b0, m32.dbz});
                chk("latency32", cyc - m32.issue, 32'd33);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done8");
            end else begin
                m8 = q8.pop_front();
                chk("lo8", {24'b0, lo8}, m8.lo);
                chk("hi8", {24'b0, hi8}, m8.hi);
                chk("dbz8", {31'b0, dbz8}, {31'b0, m8.dbz});
                chk("latency8", cyc - m8.issue, 32'd9);
            end
        end
    end

    initial begin
        exp_t eb;
        int   k;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(0, 1, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0);
        send(0, 0, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd0, 1'b0);
        send(0, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        send(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        send(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        send(0, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        send(0, 1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

        // start re-pulsed mid-operation with different operands must be ignored
        send(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd999; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;

        // reset in the middle of an operation
        send(0, 0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        q32.delete();
        q8.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(0, 0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // back-to-back: start held high, second op accepted in the done cycle
        wait_idle(0);
        eb.lo = 32'd6; eb.hi = 32'd6; eb.dbz = 1'b0; eb.issue = cyc + 1;
        start = 1'b1; is_signed = 1'b0; dividend = 32'd48; divisor = 32'd7;
        q32.push_back(eb);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 100);
        if (!done) begin
            total++; bad++;
            $display("FAIL b2b_done_timeout");
        end
        eb.lo = 32'hFFFF_FFFB; eb.hi = 32'hFFFF_FFFF; eb.dbz = 1'b0; eb.issue = cyc + 1;
        is_signed = 1'b1; dividend = 32'hFFFF_FFF5; divisor = 32'd2;
        q32.push_back(eb);
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 150; i++) send_rand(0);
        for (int i = 0; i < 250; i++) send_rand(1);

        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        chk("drain32", q32.size(), 32'd0);
        chk("drain8", q8.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
